word_byte_serializer: RTL and testbench
=======================================

WORD_BYTE_SERIALIZER -- requirements
Module: word_byte_serializer

Interface
REQ-001 Parameter: LOW_FIRST, default 1, 1 = low byte sent first, 0 = high byte sent first.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 enable  input  1  0 = freeze all state; 1 = normal operation.
REQ-005 word_in  input  16  word to be serialized.
REQ-006 word_valid  input  1  word_in is valid.
REQ-007 word_ready  output  1  block accepts word_in this cycle.
REQ-008 byte_out  output  8  current byte.
REQ-009 LH  output  1  half-select for byte_out: 0 = bits[7:0], 1 = bits[15:8]; directly drives a byte-loaded 16-bit register's LH input.
REQ-010 byte_valid  output  1  byte_out/LH are valid.
REQ-011 byte_ready  input  1  consumer takes byte this cycle.
REQ-012 words_sent  output  8  count of fully transmitted words, wrapping.

Function
REQ-013 The word transfer SHALL occur on a rising edge with word_valid && word_ready; the byte transfer SHALL occur with byte_valid && byte_ready.
REQ-014 FSM states SHALL be IDLE, FIRST, SECOND.
REQ-015 word_ready SHALL be combinational: enable && (state==IDLE || (state==SECOND && byte_ready)).
REQ-016 byte_valid SHALL equal enable && (state==FIRST || state==SECOND).
REQ-017 On a word transfer, the block SHALL capture word_in into a 16-bit holding register and enter FIRST; first byte valid the next cycle (latency 1).
REQ-018 In FIRST, byte_out/LH SHALL present the first half per LOW_FIRST (LOW_FIRST=1: [7:0], LH=0; else [15:8], LH=1).
REQ-019 FIRST with byte transfer SHALL go to SECOND; SECOND SHALL present the other half with LH inverted.
REQ-020 SECOND with byte transfer SHALL increment words_sent modulo 256 (255 -> 0).
REQ-021 SECOND with byte transfer and word_valid SHALL capture the new word and go to FIRST with no bubble; without word_valid it SHALL go to IDLE.
REQ-022 Sustained throughput SHALL be one word per 2 cycles with byte_ready and word_valid held high.
REQ-023 byte_out and LH SHALL remain stable while byte_valid && !byte_ready.
REQ-024 With enable=0, state, holding register and words_sent SHALL hold; word_ready and byte_valid SHALL be 0; byte_out/LH SHALL hold their values.
REQ-025 word_valid SHALL be ignored whenever word_ready is 0; byte_ready SHALL be ignored whenever byte_valid is 0.
REQ-026 In IDLE, byte_out and LH SHALL hold their last driven values.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, holding register 0, byte_out 0, LH 0, words_sent 0; byte_valid therefore 0.
REQ-028 Reset asserted mid-word SHALL discard the partially sent word without incrementing words_sent.
REQ-029 After rst_n deasserts, word_ready SHALL be 1 in the first cycle if enable=1.

Structure
REQ-030 A shared package SHALL hold the state typedef (IDLE, FIRST, SECOND) and constants LH_LOW=0, LH_HIGH=1.
REQ-031 The block SHALL be a single module with no sub-module; one sequential FSM process plus combinational handshake outputs.

Verification
REQ-032 LOW_FIRST=1, word_in=16'hA55A accepted, byte_ready=1 -> next cycle byte_out=8'h5A LH=0, following cycle 8'hA5 LH=1, words_sent=1.
REQ-033 LOW_FIRST=0, word_in=16'h1234 -> bytes 8'h12 LH=1 then 8'h34 LH=0.
REQ-034 Back-to-back 16'h0102, 16'h0304 with byte_ready=1 -> bytes 02,01,04,03 on 4 consecutive cycles, words_sent=2.
REQ-035 byte_ready=0 for 3 cycles in FIRST -> byte_out/LH constant, word_ready=0; then completes normally; enable=0 for 2 cycles mid-word -> byte_valid=0, resumes same byte.
REQ-036 Send 256 words -> words_sent wraps to 0; rst_n pulsed low in SECOND -> IDLE, byte_valid=0, words_sent=0 immediately.

Source files
------------

// File: rtl/word_byte_serializer_pkg.sv
// Shared types and constants for the 16-bit word to byte serializer.
package word_byte_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  localparam logic LH_LOW  = 1'b0;
  localparam logic LH_HIGH = 1'b1;

  function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Splits each accepted 16-bit word into two bytes tagged with a half-select (LH).
// Latency: first byte valid one cycle after word accept; back-to-back words with no bubble.
// Backpressure: byte_ready low holds byte_out/LH and blocks word_ready; enable low freezes all.
module word_byte_serializer
  import word_byte_serializer_pkg::*;
#(
  parameter int LOW_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [7:0]  byte_out,
  output logic        LH,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  words_sent
);

  localparam logic FIRST_LH = (LOW_FIRST != 0) ? LH_LOW : LH_HIGH;

  state_t      state;
  logic [15:0] hold;

  assign word_ready = enable && (state == IDLE || (state == SECOND && byte_ready));
  assign byte_valid = enable && (state == FIRST || state == SECOND);

  // byte_out/LH are loaded one step ahead so they are registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold       <= 16'h0000;
      byte_out   <= 8'h00;
      LH         <= LH_LOW;
      words_sent <= 8'h00;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (word_valid) begin
            hold     <= word_in;
            byte_out <= pick_byte(word_in, FIRST_LH);
            LH       <= FIRST_LH;
            state    <= FIRST;
          end
        end
        FIRST: begin
          if (byte_ready) begin
            byte_out <= pick_byte(hold, ~FIRST_LH);
            LH       <= ~FIRST_LH;
            state    <= SECOND;
          end
        end
        SECOND: begin
          if (byte_ready) begin
            words_sent <= words_sent + 8'd1;
            if (word_valid) begin
              hold     <= word_in;
              byte_out <= pick_byte(word_in, FIRST_LH);
              LH       <= FIRST_LH;
              state    <= FIRST;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_byte_serializer.sv
// Directed bench for word_byte_serializer: low-first and high-first instances share stimulus.
module tb_word_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] word_in;
  logic        word_valid;
  logic        byte_ready;

  logic        word_ready, byte_valid, LH;
  logic [7:0]  byte_out, words_sent;
  logic        hf_word_ready, hf_byte_valid, hf_LH;
  logic [7:0]  hf_byte_out, hf_words_sent;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  word_byte_serializer #(.LOW_FIRST(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .byte_out   (byte_out),
    .LH         (LH),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .words_sent (words_sent)
  );

  word_byte_serializer #(.LOW_FIRST(0)) dut_hf (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (hf_word_ready),
    .byte_out   (hf_byte_out),
    .LH         (hf_LH),
    .byte_valid (hf_byte_valid),
    .byte_ready (byte_ready),
    .words_sent (hf_words_sent)
  );

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated word on the low-first instance, checking both bytes.
  task automatic send_word(input logic [15:0] w);
    logic [15:0] wt;
    wt = w;
    word_in    = wt;
    word_valid = 1'b1;
    byte_ready = 1'b1;
    tick();
    word_valid = 1'b0;
    #1;
    check_val("loop_b0", 16'(byte_out), {8'h00, wt[7:0]});
    tick();
    check_val("loop_b1", 16'(byte_out), {8'h00, wt[15:8]});
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    word_in    = 16'h0000;
    word_valid = 1'b0;
    byte_ready = 1'b0;
    #12;
    check_val("rst_byte_out",   16'(byte_out),   16'h0000);
    check_val("rst_lh",         16'(LH),         16'h0000);
    check_val("rst_words_sent", 16'(words_sent), 16'h0000);
    check_val("rst_byte_valid", 16'(byte_valid), 16'h0000);
    check_val("rst_word_ready_dis", 16'(word_ready), 16'h0000);

    enable = 1'b1;
    rst_n  = 1'b1;
    #1;
    check_val("post_rst_word_ready", 16'(word_ready), 16'h0001);

    // Single word, low first and high first
    word_in    = 16'hA55A;
    word_valid = 1'b1;
    byte_ready = 1'b1;
    tick();
    word_valid = 1'b0;
    #1;
    check_val("a55a_b0",       16'(byte_out),    16'h005A);
    check_val("a55a_lh0",      16'(LH),          16'h0000);
    check_val("a55a_vld0",     16'(byte_valid),  16'h0001);
    check_val("a55a_wrdy0",    16'(word_ready),  16'h0000);
    check_val("a55a_hf_b0",    16'(hf_byte_out), 16'h00A5);
    check_val("a55a_hf_lh0",   16'(hf_LH),       16'h0001);
    tick();
    check_val("a55a_b1",       16'(byte_out),    16'h00A5);
    check_val("a55a_lh1",      16'(LH),          16'h0001);
    check_val("a55a_wrdy1",    16'(word_ready),  16'h0001);
    check_val("a55a_hf_b1",    16'(hf_byte_out), 16'h005A);
    check_val("a55a_hf_lh1",   16'(hf_LH),       16'h0000);
    tick();
    check_val("a55a_ws",       16'(words_sent),  16'h0001);
    check_val("idle_vld",      16'(byte_valid),  16'h0000);
    check_val("idle_hold_b",   16'(byte_out),    16'h00A5);
    check_val("idle_hold_lh",  16'(LH),          16'h0001);

    word_in    = 16'h1234;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    #1;
    check_val("hf1234_b0",  16'(hf_byte_out), 16'h0012);
    check_val("hf1234_lh0", 16'(hf_LH),       16'h0001);
    tick();
    check_val("hf1234_b1",  16'(hf_byte_out), 16'h0034);
    check_val("hf1234_lh1", 16'(hf_LH),       16'h0000);
    tick();
    check_val("hf1234_ws",  16'(hf_words_sent), 16'h0002);

    // Back-to-back words with no bubble
    word_in    = 16'h0102;
    word_valid = 1'b1;
    tick();
    word_in = 16'h0304;
    #1;
    check_val("b2b_0", 16'(byte_out), 16'h0002);
    tick();
    check_val("b2b_1", 16'(byte_out), 16'h0001);
    check_val("b2b_wrdy", 16'(word_ready), 16'h0001);
    tick();
    word_valid = 1'b0;
    #1;
    check_val("b2b_2", 16'(byte_out), 16'h0004);
    check_val("b2b_2_lh", 16'(LH), 16'h0000);
    tick();
    check_val("b2b_3", 16'(byte_out), 16'h0003);
    tick();
    check_val("b2b_ws", 16'(words_sent), 16'h0004);

    // Stall in FIRST, then freeze mid-word
    word_in    = 16'hBEEF;
    word_valid = 1'b1;
    byte_ready = 1'b0;
    tick();
    word_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val("stall_b",    16'(byte_out),   16'h00EF);
      check_val("stall_lh",   16'(LH),         16'h0000);
      check_val("stall_wrdy", 16'(word_ready), 16'h0000);
      check_val("stall_vld",  16'(byte_valid), 16'h0001);
      tick();
    end
    enable = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_val("frz_vld",  16'(byte_valid), 16'h0000);
      check_val("frz_wrdy", 16'(word_ready), 16'h0000);
      check_val("frz_b",    16'(byte_out),   16'h00EF);
      tick();
    end
    enable     = 1'b1;
    byte_ready = 1'b1;
    #1;
    check_val("resume_vld", 16'(byte_valid), 16'h0001);
    check_val("resume_b",   16'(byte_out),   16'h00EF);
    tick();
    check_val("beef_b1",  16'(byte_out), 16'h00BE);
    check_val("beef_lh1", 16'(LH),       16'h0001);
    enable = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_val("frz2_vld",  16'(byte_valid), 16'h0000);
      check_val("frz2_wrdy", 16'(word_ready), 16'h0000);
      check_val("frz2_b",    16'(byte_out),   16'h00BE);
      tick();
    end
    check_val("frz2_ws", 16'(words_sent), 16'h0004);
    enable = 1'b1;
    #1;
    check_val("second_wrdy", 16'(word_ready), 16'h0001);
    tick();
    check_val("beef_ws", 16'(words_sent), 16'h0005);

    // Wrap words_sent through 255 -> 0
    for (int i = 0; i < 251; i++) begin
      send_word(16'(i * 16'h0103 + 16'h1000));
    end
    check_val("wrap_ws", 16'(words_sent), 16'h0000);
    send_word(16'h7788);
    check_val("after_wrap_ws", 16'(words_sent), 16'h0001);

    // Reset while SECOND is stalled
    word_in    = 16'hCAFE;
    word_valid = 1'b1;
    byte_ready = 1'b1;
    tick();
    word_valid = 1'b0;
    tick();
    byte_ready = 1'b0;
    #1;
    check_val("pre_rst_b", 16'(byte_out), 16'h00CA);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_vld",  16'(byte_valid), 16'h0000);
    check_val("mid_rst_ws",   16'(words_sent), 16'h0000);
    check_val("mid_rst_b",    16'(byte_out),   16'h0000);
    check_val("mid_rst_lh",   16'(LH),         16'h0000);
    check_val("mid_rst_wrdy", 16'(word_ready), 16'h0001);
    rst_n = 1'b1;
    tick();
    check_val("post_rst2_vld", 16'(byte_valid), 16'h0000);
    check_val("post_rst2_ws",  16'(words_sent), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
